// File: rtl/ag_seq_pkg.sv
// Shared definitions for the multi-beat AG address sequencer:
// access-size encodings, FSM state type and the size decode helper.
package ag_seq_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_WORD  = 2'b01;
    localparam logic [1:0] SZ_DWORD = 2'b10;
    localparam logic [1:0] SZ_QWORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_SPLIT2,
        ST_DRAIN
    } ag_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        logic [3:0] n;
        unique case (sz)
            SZ_BYTE:  n = 4'd1;
            SZ_WORD:  n = 4'd2;
            SZ_DWORD: n = 4'd4;
            SZ_QWORD: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ag_beat_calc.sv
// Per-element address math: linear address, line-split detection with the
// two beat halves, and the inclusive segment-limit check.
module ag_beat_calc
    import ag_seq_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic [ADDR_W-1:0] off,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    input  logic [1:0]        size,
    output logic [ADDR_W-1:0] lin,
    output logic              split,
    output logic [3:0]        first_bytes,
    output logic [ADDR_W-1:0] sec_addr,
    output logic [3:0]        sec_bytes,
    output logic              fault
);

    localparam int LB_W = $clog2(LINE_BYTES);

    logic [3:0]        sz;
    logic [LB_W:0]     r_ext;
    logic [LB_W:0]     room;
    logic [ADDR_W:0]   end_off;

    assign sz    = size_bytes(size);
    assign lin   = base + off;
    assign r_ext = {1'b0, lin[LB_W-1:0]};
    assign room  = (LB_W+1)'(LINE_BYTES) - r_ext;

    // r + size stays below 2*LINE_BYTES because LINE_BYTES >= 8, so LB_W+1 bits suffice
    assign split       = (r_ext + (LB_W+1)'(sz)) > (LB_W+1)'(LINE_BYTES);
    assign first_bytes = split ? 4'(room) : sz;
    assign sec_addr    = lin + ADDR_W'(room);
    assign sec_bytes   = sz - first_bytes;

    // Last byte of the element, one extra bit to catch wrap past 2^ADDR_W
    assign end_off = {1'b0, off} + (ADDR_W+1)'(sz) - (ADDR_W+1)'(1);
    assign fault   = end_off[ADDR_W] | (end_off[ADDR_W-1:0] > limit);

endmodule

// File: rtl/address_generation_seq.sv
// Multi-beat AG sequencer: walks one descriptor element by element, splits
// line-crossing elements into two beats and aborts on a segment-limit fault.
module address_generation_seq
    import ag_seq_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MAX_ELEMS  = 8,
    parameter int LINE_BYTES = 16,
    parameter int CNT_W      = $clog2(MAX_ELEMS+1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              IN_V,
    output logic              IN_READY,
    input  logic [ADDR_W-1:0] IN_OFFSET,
    input  logic [ADDR_W-1:0] IN_SEG_BASE,
    input  logic [ADDR_W-1:0] IN_SEG_LIMIT,
    input  logic [1:0]        IN_DATA_SIZE,
    input  logic              IN_DIR,
    input  logic [CNT_W-1:0]  IN_COUNT,
    output logic              OUT_V,
    input  logic              OUT_READY,
    output logic [ADDR_W-1:0] OUT_ADDR,
    output logic [3:0]        OUT_BYTES,
    output logic [CNT_W-1:0]  OUT_IDX,
    output logic              OUT_HALF,
    output logic              OUT_LAST,
    output logic              OUT_EXC,
    output logic              BUSY
);

    ag_state_e         state;
    logic [ADDR_W-1:0] off_r, base_r, limit_r, sec_addr_r;
    logic [1:0]        size_r;
    logic              dir_r;
    logic [CNT_W-1:0]  count_r, idx_r;
    logic              split_r, last_elem_r;
    logic [3:0]        sec_bytes_r;

    logic              out_v_r, out_half_r, out_last_r, out_exc_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic [3:0]        out_bytes_r;
    logic [CNT_W-1:0]  out_idx_r;

    logic              idle, xfer, load_next;
    logic [ADDR_W-1:0] step, c_off, c_base, c_limit;
    logic [1:0]        c_size;
    logic [CNT_W-1:0]  nxt_idx, c_count;
    logic              nxt_last;

    logic [ADDR_W-1:0] c_lin, c_sec_addr;
    logic              c_split, c_fault;
    logic [3:0]        c_first, c_sec_bytes;

    assign idle     = (state == ST_IDLE);
    assign xfer     = out_v_r & OUT_READY;
    assign IN_READY = idle & ~RST & ~FLUSH;
    assign BUSY     = ~idle;

    // In IDLE the calculator sees the incoming descriptor so element 0 is
    // ready one cycle after accept; otherwise it sees the next element.
    assign step    = ADDR_W'(size_bytes(size_r));
    assign c_off   = idle ? IN_OFFSET    : (dir_r ? off_r - step : off_r + step);
    assign c_base  = idle ? IN_SEG_BASE  : base_r;
    assign c_limit = idle ? IN_SEG_LIMIT : limit_r;
    assign c_size  = idle ? IN_DATA_SIZE : size_r;
    assign c_count = idle ? IN_COUNT     : count_r;
    assign nxt_idx = idle ? '0 : idx_r + CNT_W'(1);
    assign nxt_last = (nxt_idx == c_count - CNT_W'(1));

    ag_beat_calc #(
        .ADDR_W     (ADDR_W),
        .LINE_BYTES (LINE_BYTES)
    ) u_calc (
        .off         (c_off),
        .base        (c_base),
        .limit       (c_limit),
        .size        (c_size),
        .lin         (c_lin),
        .split       (c_split),
        .first_bytes (c_first),
        .sec_addr    (c_sec_addr),
        .sec_bytes   (c_sec_bytes),
        .fault       (c_fault)
    );

    always_comb begin
        load_next = 1'b0;
        unique case (state)
            ST_IDLE:   load_next = IN_V && (IN_COUNT != '0);
            ST_EMIT:   load_next = xfer && !split_r && !out_last_r;
            ST_SPLIT2: load_next = xfer && !out_last_r;
            default:   load_next = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            off_r       <= '0;
            base_r      <= '0;
            limit_r     <= '0;
            size_r      <= '0;
            dir_r       <= 1'b0;
            count_r     <= '0;
            idx_r       <= '0;
            split_r     <= 1'b0;
            last_elem_r <= 1'b0;
            sec_addr_r  <= '0;
            sec_bytes_r <= '0;
            out_v_r     <= 1'b0;
            out_addr_r  <= '0;
            out_bytes_r <= '0;
            out_idx_r   <= '0;
            out_half_r  <= 1'b0;
            out_last_r  <= 1'b0;
            out_exc_r   <= 1'b0;
        end else if (FLUSH) begin
            state      <= ST_IDLE;
            out_v_r    <= 1'b0;
            out_half_r <= 1'b0;
            out_last_r <= 1'b0;
            out_exc_r  <= 1'b0;
        end else begin
            if (idle && IN_V) begin
                base_r  <= IN_SEG_BASE;
                limit_r <= IN_SEG_LIMIT;
                size_r  <= IN_DATA_SIZE;
                dir_r   <= IN_DIR;
                count_r <= IN_COUNT;
            end
            if (load_next) begin
                off_r      <= c_off;
                idx_r      <= nxt_idx;
                out_v_r    <= 1'b1;
                out_addr_r <= c_lin;
                out_idx_r  <= nxt_idx;
                out_half_r <= 1'b0;
                if (c_fault) begin
                    out_exc_r   <= 1'b1;
                    out_last_r  <= 1'b1;
                    out_bytes_r <= '0;
                    state       <= ST_DRAIN;
                end else begin
                    out_exc_r   <= 1'b0;
                    out_bytes_r <= c_first;
                    out_last_r  <= nxt_last & ~c_split;
                    split_r     <= c_split;
                    last_elem_r <= nxt_last;
                    sec_addr_r  <= c_sec_addr;
                    sec_bytes_r <= c_sec_bytes;
                    state       <= ST_EMIT;
                end
            end else if (xfer) begin
                if (state == ST_EMIT && split_r) begin
                    state       <= ST_SPLIT2;
                    out_addr_r  <= sec_addr_r;
                    out_bytes_r <= sec_bytes_r;
                    out_half_r  <= 1'b1;
                    out_last_r  <= last_elem_r;
                end else begin
                    // only reached on a LAST or exception beat
                    state      <= ST_IDLE;
                    out_v_r    <= 1'b0;
                    out_half_r <= 1'b0;
                    out_last_r <= 1'b0;
                    out_exc_r  <= 1'b0;
                end
            end
        end
    end

    assign OUT_V     = out_v_r;
    assign OUT_ADDR  = out_addr_r;
    assign OUT_BYTES = out_bytes_r;
    assign OUT_IDX   = out_idx_r;
    assign OUT_HALF  = out_half_r;
    assign OUT_LAST  = out_last_r;
    assign OUT_EXC   = out_exc_r;

endmodule

// File: tb/tb_address_generation_seq.sv
// Directed bench for address_generation_seq: inputs change and outputs are
// sampled on the falling edge, expected values are hand-computed.
module tb_address_generation_seq;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              FLUSH = 1'b0;
    logic              IN_V = 1'b0;
    logic              IN_READY;
    logic [ADDR_W-1:0] IN_OFFSET = '0;
    logic [ADDR_W-1:0] IN_SEG_BASE = '0;
    logic [ADDR_W-1:0] IN_SEG_LIMIT = '0;
    logic [1:0]        IN_DATA_SIZE = '0;
    logic              IN_DIR = 1'b0;
    logic [CNT_W-1:0]  IN_COUNT = '0;
    logic              OUT_V;
    logic              OUT_READY = 1'b1;
    logic [ADDR_W-1:0] OUT_ADDR;
    logic [3:0]        OUT_BYTES;
    logic [CNT_W-1:0]  OUT_IDX;
    logic              OUT_HALF, OUT_LAST, OUT_EXC, BUSY;

    int checks = 0;
    int errors = 0;

    address_generation_seq #(
        .ADDR_W(ADDR_W), .MAX_ELEMS(8), .LINE_BYTES(16), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_V(IN_V), .IN_READY(IN_READY),
        .IN_OFFSET(IN_OFFSET), .IN_SEG_BASE(IN_SEG_BASE), .IN_SEG_LIMIT(IN_SEG_LIMIT),
        .IN_DATA_SIZE(IN_DATA_SIZE), .IN_DIR(IN_DIR), .IN_COUNT(IN_COUNT),
        .OUT_V(OUT_V), .OUT_READY(OUT_READY), .OUT_ADDR(OUT_ADDR), .OUT_BYTES(OUT_BYTES),
        .OUT_IDX(OUT_IDX), .OUT_HALF(OUT_HALF), .OUT_LAST(OUT_LAST), .OUT_EXC(OUT_EXC),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Presents one descriptor for a single cycle; returns on the next falling edge.
    task automatic send(input logic [31:0] base, input logic [31:0] limit, input logic [31:0] off,
                        input logic [1:0] sz, input logic dir, input logic [3:0] cnt);
        IN_SEG_BASE = base; IN_SEG_LIMIT = limit; IN_OFFSET = off;
        IN_DATA_SIZE = sz; IN_DIR = dir; IN_COUNT = cnt; IN_V = 1'b1;
        @(negedge CLK);
        IN_V = 1'b0;
    endtask

    // Waits (bounded) for OUT_V; a bubble is only legal before a split second half.
    task automatic wait_v(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (OUT_V === 1'b1) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
        if (!ok && OUT_V === 1'b1) ok = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (OUT_V !== 1'b0 || OUT_ADDR !== '0 || OUT_BYTES !== '0 || OUT_IDX !== '0 ||
            OUT_HALF !== 1'b0 || OUT_LAST !== 1'b0 || OUT_EXC !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b addr=%h bytes=%0d idx=%0d half=%b last=%b exc=%b busy=%b, want all 0",
                     OUT_V, OUT_ADDR, OUT_BYTES, OUT_IDX, OUT_HALF, OUT_LAST, OUT_EXC, BUSY);
        end
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b, want 0", IN_READY);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b, want 1", IN_READY);
        end
        @(negedge CLK);
    endtask

    task automatic test_single();
        send(32'h1000, 32'hFFFF, 32'h100, 2'b10, 1'b0, 4'd1);
        checks++;
        if (OUT_V !== 1'b1 || OUT_ADDR !== 32'h1100 || OUT_BYTES !== 4'd4 || OUT_IDX !== 4'd0 ||
            OUT_LAST !== 1'b1 || OUT_HALF !== 1'b0 || OUT_EXC !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL single_beat: v=%b addr=%h bytes=%0d idx=%0d last=%b half=%b exc=%b busy=%b, want v=1 addr=00001100 bytes=4 idx=0 last=1 half=0 exc=0 busy=1",
                     OUT_V, OUT_ADDR, OUT_BYTES, OUT_IDX, OUT_LAST, OUT_HALF, OUT_EXC, BUSY);
        end
        @(negedge CLK);
        checks++;
        if (OUT_V !== 1'b0 || IN_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL single_done: v=%b in_ready=%b busy=%b, want v=0 in_ready=1 busy=0", OUT_V, IN_READY, BUSY);
        end
    endtask

    task automatic test_back_to_back();
        send(32'h1000, 32'hFFFF, 32'h100, 2'b10, 1'b0, 4'd1);
        @(negedge CLK);
        send(32'h1000, 32'hFFFF, 32'h104, 2'b10, 1'b0, 4'd1);
        checks++;
        if (OUT_V !== 1'b1 || OUT_ADDR !== 32'h1104 || OUT_LAST !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: v=%b addr=%h last=%b, want v=1 addr=00001104 last=1", OUT_V, OUT_ADDR, OUT_LAST);
        end
        @(negedge CLK);
    endtask

    task automatic test_split();
        bit ok;
        send(32'h1000, 32'hFFFF, 32'h10E, 2'b10, 1'b0, 4'd1);
        checks++;
        if (OUT_V !== 1'b1 || OUT_ADDR !== 32'h110E || OUT_BYTES !== 4'd2 || OUT_HALF !== 1'b0 || OUT_LAST !== 1'b0) begin
            errors++;
            $display("FAIL split_a: v=%b addr=%h bytes=%0d half=%b last=%b, want v=1 addr=0000110e bytes=2 half=0 last=0",
                     OUT_V, OUT_ADDR, OUT_BYTES, OUT_HALF, OUT_LAST);
        end
        @(negedge CLK);
        wait_v(2, ok);
        checks++;
        if (!ok || OUT_ADDR !== 32'h1110 || OUT_BYTES !== 4'd2 || OUT_HALF !== 1'b1 || OUT_IDX !== 4'd0 || OUT_LAST !== 1'b1) begin
            errors++;
            $display("FAIL split_b: v=%b addr=%h bytes=%0d half=%b idx=%0d last=%b, want v=1 addr=00001110 bytes=2 half=1 idx=0 last=1",
                     OUT_V, OUT_ADDR, OUT_BYTES, OUT_HALF, OUT_IDX, OUT_LAST);
        end
        @(negedge CLK);
        checks++;
        if (OUT_V !== 1'b0) begin
            errors++; $display("FAIL split_end: v=%b, want 0", OUT_V);
        end
    endtask

    task automatic test_push();
        logic [31:0] ea [3] = '{32'h1200, 32'h11FC, 32'h11F8};
        send(32'h1000, 32'hFFFF, 32'h200, 2'b10, 1'b1, 4'd3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (OUT_V !== 1'b1 || OUT_ADDR !== ea[k] || OUT_BYTES !== 4'd4 || OUT_IDX !== 4'(k) ||
                OUT_LAST !== (k == 2) || OUT_EXC !== 1'b0) begin
                errors++;
                $display("FAIL push_beat%0d: v=%b addr=%h bytes=%0d idx=%0d last=%b exc=%b, want v=1 addr=%h bytes=4 idx=%0d last=%b exc=0",
                         k, OUT_V, OUT_ADDR, OUT_BYTES, OUT_IDX, OUT_LAST, OUT_EXC, ea[k], k, (k == 2));
            end
            @(negedge CLK);
        end
        checks++;
        if (OUT_V !== 1'b0 || IN_READY !== 1'b1) begin
            errors++; $display("FAIL push_end: v=%b in_ready=%b, want v=0 in_ready=1", OUT_V, IN_READY);
        end
    endtask

    task automatic test_qword();
        bit ok;
        send(32'h1000, 32'hFFFF, 32'h10C, 2'b11, 1'b0, 4'd2);
        checks++;
        if (OUT_V !== 1'b1 || OUT_ADDR !== 32'h110C || OUT_BYTES !== 4'd4 || OUT_HALF !== 1'b0 || OUT_LAST !== 1'b0) begin
            errors++;
            $display("FAIL qword_a: v=%b addr=%h bytes=%0d half=%b last=%b, want v=1 addr=0000110c bytes=4 half=0 last=0",
                     OUT_V, OUT_ADDR, OUT_BYTES, OUT_HALF, OUT_LAST);
        end
        @(negedge CLK);
        wait_v(2, ok);
        checks++;
        if (!ok || OUT_ADDR !== 32'h1110 || OUT_BYTES !== 4'd4 || OUT_HALF !== 1'b1 || OUT_IDX !== 4'd0 || OUT_LAST !== 1'b0) begin
            errors++;
            $display("FAIL qword_b: v=%b addr=%h bytes=%0d half=%b idx=%0d last=%b, want v=1 addr=00001110 bytes=4 half=1 idx=0 last=0",
                     OUT_V, OUT_ADDR, OUT_BYTES, OUT_HALF, OUT_IDX, OUT_LAST);
        end
        @(negedge CLK);
        checks++;
        if (OUT_V !== 1'b1 || OUT_ADDR !== 32'h1114 || OUT_BYTES !== 4'd8 || OUT_HALF !== 1'b0 || OUT_IDX !== 4'd1 || OUT_LAST !== 1'b1) begin
            errors++;
            $display("FAIL qword_e1: v=%b addr=%h bytes=%0d half=%b idx=%0d last=%b, want v=1 addr=00001114 bytes=8 half=0 idx=1 last=1",
                     OUT_V, OUT_ADDR, OUT_BYTES, OUT_HALF, OUT_IDX, OUT_LAST);
        end
        @(negedge CLK);
    endtask

    task automatic test_fault();
        logic [31:0] ea [3] = '{32'h1200, 32'h1202, 32'h1204};
        logic [3:0]  eb [3] = '{4'd2, 4'd2, 4'd0};
        send(32'h1000, 32'h0203, 32'h200, 2'b01, 1'b0, 4'd3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (OUT_V !== 1'b1 || OUT_ADDR !== ea[k] || OUT_BYTES !== eb[k] || OUT_IDX !== 4'(k) ||
                OUT_EXC !== (k == 2) || OUT_LAST !== (k == 2)) begin
                errors++;
                $display("FAIL fault_beat%0d: v=%b addr=%h bytes=%0d idx=%0d exc=%b last=%b, want v=1 addr=%h bytes=%0d idx=%0d exc=%b last=%b",
                         k, OUT_V, OUT_ADDR, OUT_BYTES, OUT_IDX, OUT_EXC, OUT_LAST, ea[k], eb[k], k, (k == 2), (k == 2));
            end
            @(negedge CLK);
        end
        checks++;
        if (OUT_V !== 1'b0 || IN_READY !== 1'b1 || OUT_EXC !== 1'b0) begin
            errors++; $display("FAIL fault_end: v=%b in_ready=%b exc=%b, want v=0 in_ready=1 exc=0", OUT_V, IN_READY, OUT_EXC);
        end
    endtask

    task automatic test_backpressure();
        send(32'h1000, 32'hFFFF, 32'h200, 2'b10, 1'b1, 4'd3);
        @(negedge CLK);
        OUT_READY = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (OUT_V !== 1'b1 || OUT_ADDR !== 32'h11FC || OUT_IDX !== 4'd1 || OUT_BYTES !== 4'd4 || OUT_LAST !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%b addr=%h idx=%0d bytes=%0d last=%b, want v=1 addr=000011fc idx=1 bytes=4 last=0",
                         j, OUT_V, OUT_ADDR, OUT_IDX, OUT_BYTES, OUT_LAST);
            end
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        checks++;
        if (OUT_V !== 1'b1 || OUT_ADDR !== 32'h11FC || OUT_IDX !== 4'd1) begin
            errors++; $display("FAIL bp_release: v=%b addr=%h idx=%0d, want v=1 addr=000011fc idx=1", OUT_V, OUT_ADDR, OUT_IDX);
        end
        @(negedge CLK);
        checks++;
        if (OUT_V !== 1'b1 || OUT_ADDR !== 32'h11F8 || OUT_IDX !== 4'd2 || OUT_LAST !== 1'b1) begin
            errors++; $display("FAIL bp_last: v=%b addr=%h idx=%0d last=%b, want v=1 addr=000011f8 idx=2 last=1", OUT_V, OUT_ADDR, OUT_IDX, OUT_LAST);
        end
        @(negedge CLK);
        checks++;
        if (OUT_V !== 1'b0) begin
            errors++; $display("FAIL bp_end: v=%b, want 0", OUT_V);
        end
    endtask

    task automatic test_flush();
        send(32'h1000, 32'hFFFF, 32'h200, 2'b10, 1'b1, 4'd3);
        @(negedge CLK);
        IN_SEG_BASE = 32'h1000; IN_SEG_LIMIT = 32'hFFFF; IN_OFFSET = 32'h300;
        IN_DATA_SIZE = 2'b10; IN_DIR = 1'b0; IN_COUNT = 4'd1;
        IN_V = 1'b1; FLUSH = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++; $display("FAIL flush_blocks_ready: got %b, want 0", IN_READY);
        end
        @(negedge CLK);
        IN_V = 1'b0; FLUSH = 1'b0;
        #1;
        checks++;
        if (OUT_V !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b1) begin
            errors++; $display("FAIL flush_idle: v=%b busy=%b in_ready=%b, want v=0 busy=0 in_ready=1", OUT_V, BUSY, IN_READY);
        end
        @(negedge CLK);
        checks++;
        if (OUT_V !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL flush_not_accepted: v=%b busy=%b, want v=0 busy=0", OUT_V, BUSY);
        end
    endtask

    task automatic test_rst_mid();
        send(32'h1000, 32'hFFFF, 32'h200, 2'b10, 1'b1, 4'd3);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (OUT_V !== 1'b0 || OUT_ADDR !== '0 || OUT_BYTES !== '0 || OUT_IDX !== '0 ||
            OUT_HALF !== 1'b0 || OUT_LAST !== 1'b0 || OUT_EXC !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: v=%b addr=%h bytes=%0d idx=%0d half=%b last=%b exc=%b busy=%b in_ready=%b, want all 0",
                     OUT_V, OUT_ADDR, OUT_BYTES, OUT_IDX, OUT_HALF, OUT_LAST, OUT_EXC, BUSY, IN_READY);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (IN_READY !== 1'b1 || OUT_V !== 1'b0) begin
            errors++; $display("FAIL rst_mid_release: in_ready=%b v=%b, want in_ready=1 v=0", IN_READY, OUT_V);
        end
    endtask

    task automatic test_count_zero();
        send(32'h1000, 32'hFFFF, 32'h100, 2'b10, 1'b0, 4'd0);
        checks++;
        if (OUT_V !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b1) begin
            errors++; $display("FAIL count_zero: v=%b busy=%b in_ready=%b, want v=0 busy=0 in_ready=1", OUT_V, BUSY, IN_READY);
        end
        @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_single();
        test_back_to_back();
        test_split();
        test_push();
        test_qword();
        test_fault();
        test_backpressure();
        test_count_zero();
        test_flush();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
